// File: rtl/mc_control_pkg.sv
// Shared definitions for the multicycle MIPS main controller: state encodings,
// opcode/funct constants, ALU control codes and datapath mux select codes.
// Optional feature macro: MC_CTRL_ADDI_EN (addi decode and its two states).
package mc_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  // How the ALU control is derived in the current state
  typedef enum logic [1:0] {
    ALUOP_NONE  = 2'd0,
    ALUOP_ADD   = 2'd1,
    ALUOP_SUB   = 2'd2,
    ALUOP_FUNCT = 2'd3
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUSRCB_REG   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True when DECODE knows where to send this opcode
  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
         (op == OP_BEQ) || (op == OP_J);
`ifdef MC_CTRL_ADDI_EN
    ok = ok || (op == OP_ADDI);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flag toward the
// controller, mux selects and write enables toward the datapath.
interface mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en;
  logic       iord;
  logic       mem_we;
  logic       ir_we;
  logic       reg_we;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alu_ctl;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero,
    output pc_en, iord, mem_we, ir_we, reg_we, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alu_ctl, illegal_op, state
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_en, iord, mem_we, ir_we, reg_we, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alu_ctl, illegal_op, state
  );
endinterface

// File: rtl/mc_control_alu_decoder.sv
// ALU control decoder: turns the state-derived ALU operation class and the
// R-type funct field into the 3-bit ALU control code.
module alu_decoder
  import mc_control_pkg::*;
(
  input  alu_op_e    alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctl_o
);

  // Fixed add/sub for address and branch math; funct lookup for R-type
  always_comb begin
    alu_ctl_o = 3'b000;
    case (alu_op_i)
      ALUOP_ADD: alu_ctl_o = ALU_ADD;
      ALUOP_SUB: alu_ctl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_ctl_o = ALU_ADD;
          FN_SUB:  alu_ctl_o = ALU_SUB;
          FN_AND:  alu_ctl_o = ALU_AND;
          FN_OR:   alu_ctl_o = ALU_OR;
          FN_SLT:  alu_ctl_o = ALU_SLT;
          default: alu_ctl_o = ALU_ADD;
        endcase
      end
      default: alu_ctl_o = 3'b000;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch, decode,
// execute, memory and writeback; drives every datapath select and enable.
// Optional feature macro: MC_CTRL_ADDI_EN adds the addi decode path.
module mc_control
  import mc_control_pkg::*;
(
  input logic          clk,
  input logic          reset,
  mc_control_if.master ctl
);

  state_e     state_q, state_d;
  alu_op_e    alu_op;
  logic       pc_en, iord, mem_we, ir_we, reg_we, regdst, memtoreg, alusrca;
  logic       illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alu_ctl;

  // State register; reset aborts any instruction and returns to FETCH at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state sequencing; unused encodings fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (ctl.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (ctl.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX:  state_d = S_ADDIWB;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  // Per-state datapath controls; anything not set for a state stays 0
  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = ALUSRCB_REG;
    pcsrc      = PCSRC_ALU;
    alu_op     = ALUOP_NONE;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = ALUSRCB_FOUR;
        alu_op  = ALUOP_ADD;
        ir_we   = 1'b1;
        pc_en   = 1'b1;
      end
      S_DECODE: begin
        alusrcb    = ALUSRCB_IMMSH;
        alu_op     = ALUOP_ADD;
        illegal_op = !op_supported(ctl.opcode);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
        alu_op  = ALUOP_ADD;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWR: begin
        iord   = 1'b1;
        mem_we = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        reg_we   = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst = 1'b1;
        reg_we = 1'b1;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
        alu_op  = ALUOP_ADD;
      end
      S_ADDIWB: reg_we = 1'b1;
`endif
      S_BRANCH: begin
        alusrca = 1'b1;
        alu_op  = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        pc_en   = ctl.zero;
      end
      S_JUMP: begin
        pcsrc = PCSRC_JUMP;
        pc_en = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i  (alu_op),
    .funct_i   (ctl.funct),
    .alu_ctl_o (alu_ctl)
  );

  assign ctl.pc_en      = pc_en;
  assign ctl.iord       = iord;
  assign ctl.mem_we     = mem_we;
  assign ctl.ir_we      = ir_we;
  assign ctl.reg_we     = reg_we;
  assign ctl.regdst     = regdst;
  assign ctl.memtoreg   = memtoreg;
  assign ctl.alusrca    = alusrca;
  assign ctl.alusrcb    = alusrcb;
  assign ctl.pcsrc      = pcsrc;
  assign ctl.alu_ctl    = alu_ctl;
  assign ctl.illegal_op = illegal_op;
  assign ctl.state      = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed instructions from the test
// plan followed by random instruction streams, each cycle compared against
// a table-driven model of the instruction state paths and per-state controls.
module tb_mc_control;

  typedef int path_t[$];

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mc_control_if ctl ();

  mc_control dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (ctl)
  );

  always #5 clk = ~clk;

  // Model: sequence of state numbers an instruction visits, starting at FETCH
  function automatic path_t path_of(input logic [5:0] op);
    path_t p;
    p = '{0, 1};
    if (op == 6'b100011)      p = '{0, 1, 2, 3, 4};
    else if (op == 6'b101011) p = '{0, 1, 2, 5};
    else if (op == 6'b000000) p = '{0, 1, 6, 7};
    else if (op == 6'b000100) p = '{0, 1, 8};
    else if (op == 6'b000010) p = '{0, 1, 11};
`ifdef MC_CTRL_ADDI_EN
    else if (op == 6'b001000) p = '{0, 1, 9, 10};
`endif
    return p;
  endfunction

  function automatic logic legal(input logic [5:0] op);
    path_t p;
    p = path_of(op);
    return p.size() > 2;
  endfunction

  function automatic logic [2:0] funct_ctl(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Pack {pc_en,iord,mem_we,ir_we,reg_we,regdst,memtoreg,alusrca,alusrcb,pcsrc,alu_ctl,illegal}
  function automatic logic [15:0] mk(input logic pe, io, mw, iw, rw, rd, mr, sa,
                                     input logic [1:0] sb, ps, input logic [2:0] ac,
                                     input logic ill);
    return {pe, io, mw, iw, rw, rd, mr, sa, sb, ps, ac, ill};
  endfunction

  function automatic logic [15:0] exp_out(input int s, input logic [5:0] op,
                                          input logic [5:0] fn, input logic z);
    case (s)
      0:  return mk(1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
      1:  return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, !legal(op));
      2:  return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
      3:  return mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
      4:  return mk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0);
      5:  return mk(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
      6:  return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, funct_ctl(fn), 0);
      7:  return mk(0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 0);
      8:  return mk(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0);
      9:  return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
      10: return mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
      11: return mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 0);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] obs_out();
    return {ctl.pc_en, ctl.iord, ctl.mem_we, ctl.ir_we, ctl.reg_we, ctl.regdst,
            ctl.memtoreg, ctl.alusrca, ctl.alusrcb, ctl.pcsrc, ctl.alu_ctl,
            ctl.illegal_op};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one instruction from FETCH and check every cycle until the next FETCH
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input string tag);
    path_t p;
    p = path_of(op);
    ctl.opcode = op;
    ctl.funct  = fn;
    ctl.zero   = z;
    #1;
    for (int k = 0; k < p.size(); k++) begin
      chk($sformatf("%s.c%0d.state", tag, k + 1), {12'h0, ctl.state}, 16'(p[k]));
      chk($sformatf("%s.c%0d.ctl", tag, k + 1), obs_out(), exp_out(p[k], op, fn, z));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [5:0] ops[7];
    logic [5:0] fns[5];
    logic [5:0] op, fn;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    ctl.opcode = 6'b100011;
    ctl.funct  = 6'b000000;
    ctl.zero   = 1'b0;

    // Asynchronous reset with no clock edge yet
    #1 reset = 1'b1;
    #1;
    chk("reset.state", {12'h0, ctl.state}, 16'd0);
    chk("reset.ctl", obs_out(), exp_out(0, 6'b100011, 6'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;

    // lw interrupted by reset in MEMRD
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort.memrd", {12'h0, ctl.state}, 16'd3);
    #1 reset = 1'b1;
    #1;
    chk("abort.state", {12'h0, ctl.state}, 16'd0);
    chk("abort.ctl", obs_out(), exp_out(0, 6'b100011, 6'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort.release", {12'h0, ctl.state}, 16'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    chk("abort.back", {12'h0, ctl.state}, 16'd0);

    // Directed instructions
    run_instr(6'b100011, 6'b000000, 1'b0, "lw");
    run_instr(6'b000000, 6'b100000, 1'b0, "add");
    run_instr(6'b000000, 6'b101010, 1'b1, "slt");
    run_instr(6'b000100, 6'b000000, 1'b1, "beq_taken");
    run_instr(6'b000100, 6'b000000, 1'b0, "beq_not");
    run_instr(6'b101011, 6'b000000, 1'b1, "sw");
    run_instr(6'b000010, 6'b000000, 1'b0, "j");
    run_instr(6'b111111, 6'b100010, 1'b0, "illegal");
    run_instr(6'b001000, 6'b000000, 1'b0, "addi");
    run_instr(6'b000000, 6'b000111, 1'b0, "rtype_badfunct");

    // Random instruction stream
    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = int'($urandom_range(0, 7));
      op  = (sel < 7) ? ops[sel] : 6'($urandom);
      sel = int'($urandom_range(0, 5));
      fn  = (sel < 5) ? fns[sel] : 6'($urandom);
      run_instr(op, fn, 1'($urandom), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle MIPS main controller: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath `mux_2d` select line and every write enable. It consumes `opcode`/`funct` from the instruction register and `zero` from the ALU. It is the producer side of the mux-select interface that the datapath muxes consume.

## Interface
- Parameters: none (widths fixed by the MIPS ISA).
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high; forces state FETCH.
- `opcode` input 6: IR[31:26]; stable from DECODE until return to FETCH.
- `funct` input 6: IR[5:0]; same stability rule as `opcode`.
- `zero` input 1: ALU zero flag.
- `pc_en` output 1: PC register write enable.
- `iord` output 1: memory address mux select (0 = PC, 1 = ALUOut).
- `mem_we` output 1: data memory write enable.
- `ir_we` output 1: instruction register write enable.
- `reg_we` output 1: register file write enable.
- `regdst` output 1: write-register mux select (0 = rt, 1 = rd).
- `memtoreg` output 1: write-data mux select (0 = ALUOut, 1 = MDR).
- `alusrca` output 1: ALU A mux select (0 = PC, 1 = rs reg).
- `alusrcb` output 2: ALU B mux select (00 rt reg, 01 const 4, 10 sign-ext imm, 11 imm<<2).
- `pcsrc` output 2: PC source select (00 ALU result, 01 ALUOut, 10 jump target).
- `alu_ctl` output 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal_op` output 1: high in a DECODE cycle whose opcode is unsupported.
- `state` output 4: current state, for debug/bench.

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Transitions:
  - FETCH→DECODE.
  - DECODE on lw(100011)/sw(101011)→MEMADR; R-type(000000)→EXECUTE; beq(000100)→BRANCH; j(000010)→JUMP; addi(001000)→ADDIEX; any other opcode→FETCH with `illegal_op`=1.
  - MEMADR→MEMRD for lw, →MEMWR for sw.
  - MEMRD→MEMWB.
  - EXECUTE→ALUWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP→FETCH.
  - Encodings 12–15 → FETCH; all outputs 0 while in them.
- Outputs are a pure function of state (`alu_ctl` also uses `funct` in EXECUTE; `pc_en` also uses `zero` in BRANCH). Any output not listed for a state is 0.
  - FETCH: iord=0, alusrca=0, alusrcb=01, alu_ctl=010, ir_we=1, pcsrc=00, pc_en=1.
  - DECODE: alusrca=0, alusrcb=11, alu_ctl=010.
  - MEMADR, ADDIEX: alusrca=1, alusrcb=10, alu_ctl=010.
  - MEMRD: iord=1.
  - MEMWR: iord=1, mem_we=1.
  - MEMWB: regdst=0, memtoreg=1, reg_we=1.
  - EXECUTE: alusrca=1, alusrcb=00, alu_ctl from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; other funct → 010).
  - ALUWB: regdst=1, memtoreg=0, reg_we=1.
  - ADDIWB: regdst=0, memtoreg=0, reg_we=1.
  - BRANCH: alusrca=1, alusrcb=00, alu_ctl=110, pcsrc=01, pc_en=`zero`.
  - JUMP: pcsrc=10, pc_en=1.

## Timing
- State register updates on rising `clk`. `reset` clears state to FETCH immediately, without waiting for a clock edge.
- Reset-time outputs are the FETCH values: pc_en=1, ir_we=1, alusrcb=01, alu_ctl=010, all else 0, state=0.
- Reset asserted mid-instruction aborts it. No write enable other than FETCH's `pc_en`/`ir_we` may be high while `reset`=1.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Outputs settle combinationally after the clock edge; the datapath samples them at the next edge.

## Configuration
- `MC_CTRL_ADDI_EN`: when defined, the ADDIEX and ADDIWB states and the addi decode exist.
- When undefined, opcode 001000 is illegal (DECODE→FETCH with `illegal_op`=1), and encodings 9/10 behave as unused.

## Structure
- Package `mc_control_pkg` holds the state encodings, opcode constants, funct constants, `alu_ctl` codes and the `alusrcb`/`pcsrc` select codes.
- One sub-module, `alu_decoder`: combinational map from (state-derived alu_op, funct) to `alu_ctl`.

## Test plan
- Reset pulse mid-MEMRD → state=0 immediately; after release, next edge gives state=1.
- lw (100011) → states 0,1,2,3,4,0; `reg_we`=`memtoreg`=1 only in cycle 5; `iord`=1 in cycle 4.
- R-type add (000000/100000), then slt (101010) → EXECUTE `alu_ctl`=010 then 111; ALUWB regdst=1, reg_we=1.
- beq with zero=1 → `pc_en`=1, pcsrc=01 in BRANCH; repeat with zero=0 → `pc_en`=0; both return to FETCH.
- sw → `mem_we`=1 for exactly one cycle (MEMWR); j → pcsrc=10, pc_en=1 in the 3rd cycle.
- Opcode 111111 → `illegal_op`=1 in DECODE, then FETCH. addi → 4 cycles with the macro defined; `illegal_op` without it.
